// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter: FSM states, field widths, reset values.
package i2c_arb_pkg;

  localparam int CHIP_W = 7;
  localparam int DATA_W = 8;

  localparam logic [CHIP_W-1:0] CHIP_RST = '0;
  localparam logic [DATA_W-1:0] DATA_RST = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_WAIT_DONE,
    ST_RESP
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester and I2C-master signal bundle for i2c_bus_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface i2c_bus_arbiter_if #(parameter int NUM_REQ = 2);
  import i2c_arb_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [CHIP_W*NUM_REQ-1:0] req_chip_addr;
  logic [DATA_W*NUM_REQ-1:0] req_reg_addr;
  logic [DATA_W*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]        req_is_read;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_seen;
  logic [CHIP_W-1:0]         i2c_chip_addr;
  logic [DATA_W-1:0]         i2c_reg_addr;
  logic [DATA_W-1:0]         i2c_value;
  logic                      i2c_is_read;
  logic                      i2c_enable;
  logic [DATA_W-1:0]         i2c_data;
  logic                      i2c_done;
  logic                      i2c_ack_error;

  modport master (
    input  req_valid, req_lock, req_chip_addr, req_reg_addr, req_value, req_is_read,
    input  i2c_data, i2c_done, i2c_ack_error,
    output req_ack, rsp_data, rsp_err, grant_id, busy, timeout_seen,
    output i2c_chip_addr, i2c_reg_addr, i2c_value, i2c_is_read, i2c_enable
  );

  modport slave (
    output req_valid, req_lock, req_chip_addr, req_reg_addr, req_value, req_is_read,
    output i2c_data, i2c_done, i2c_ack_error,
    input  req_ack, rsp_data, rsp_err, grant_id, busy, timeout_seen,
    input  i2c_chip_addr, i2c_reg_addr, i2c_value, i2c_is_read, i2c_enable
  );

endinterface

// File: rtl/i2c_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping to 0.
module i2c_arb_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin : p_pick
    int              j;
    logic [ID_W-1:0] sel;
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = ID_W'(j);
      if (!found_o && req_i[sel]) begin
        found_o = 1'b1;
        idx_o   = sel;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter serialising register transactions from NUM_REQ controllers onto one I2C master.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd16_000_000
) (
  input logic             clk,
  input logic             reset,
  i2c_bus_arbiter_if.master bus
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_e          state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     grant_q;
  logic                lock_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                busy_q;
  logic [CHIP_W-1:0]   chip_q;
  logic [DATA_W-1:0]   reg_q;
  logic [DATA_W-1:0]   val_q;
  logic                rd_q;
  logic                en_q;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0]         timer_q;
  logic                tmo_q;
  logic                tmo_seen_q;
`endif

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic                win_valid_d;
  logic [ID_W-1:0]     win_idx_d;
  logic [ID_W-1:0]     ptr_d;
  logic                keep_lock_d;

  logic [CHIP_W-1:0]   chip_arr [NUM_REQ];
  logic [DATA_W-1:0]   reg_arr  [NUM_REQ];
  logic [DATA_W-1:0]   val_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign chip_arr[i] = bus.req_chip_addr[CHIP_W*i +: CHIP_W];
    assign reg_arr[i]  = bus.req_reg_addr[DATA_W*i +: DATA_W];
    assign val_arr[i]  = bus.req_value[DATA_W*i +: DATA_W];
  end

  i2c_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // A held lock narrows the choice to the lock owner, even if it is not requesting.
  always_comb begin
    win_valid_d = lock_q ? bus.req_valid[grant_q] : pick_found;
    win_idx_d   = lock_q ? grant_q : pick_idx;
    ptr_d       = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
    keep_lock_d = bus.req_lock[grant_q] && !tmo_q;
`else
    keep_lock_d = bus.req_lock[grant_q];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
      ack_q      <= '0;
      rsp_data_q <= DATA_RST;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      chip_q     <= CHIP_RST;
      reg_q      <= DATA_RST;
      val_q      <= DATA_RST;
      rd_q       <= 1'b0;
      en_q       <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      timer_q    <= '0;
      tmo_q      <= 1'b0;
      tmo_seen_q <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (bus.i2c_done && win_valid_d) begin
            chip_q  <= chip_arr[win_idx_d];
            reg_q   <= reg_arr[win_idx_d];
            val_q   <= val_arr[win_idx_d];
            rd_q    <= bus.req_is_read[win_idx_d];
            grant_q <= win_idx_d;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          en_q    <= 1'b0;
          state_q <= ST_GAP;
`ifdef I2C_ARB_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        // i2c_done may still show the pre-start idle level here, so it is not looked at.
        ST_GAP: begin
          state_q <= ST_WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
          timer_q <= timer_q + 32'd1;
`endif
        end
        ST_WAIT_DONE: begin
          if (bus.i2c_done) begin
            rsp_data_q <= rd_q ? bus.i2c_data : DATA_RST;
            rsp_err_q  <= bus.i2c_ack_error;
            ack_q      <= NUM_REQ'(1) << grant_q;
            busy_q     <= 1'b0;
            state_q    <= ST_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (timer_q + 32'd1 >= TIMEOUT_CYCLES - 32'd1) begin
            rsp_data_q <= DATA_RST;
            rsp_err_q  <= 1'b1;
            ack_q      <= NUM_REQ'(1) << grant_q;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b1;
            tmo_seen_q <= 1'b1;
            state_q    <= ST_RESP;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
`endif
        end
        ST_RESP: begin
          ack_q <= '0;
          if (keep_lock_d) begin
            lock_q <= 1'b1;
          end else begin
            lock_q <= 1'b0;
            ptr_q  <= ptr_d;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          tmo_q <= 1'b0;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ack       = ack_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = busy_q;
  assign bus.i2c_chip_addr = chip_q;
  assign bus.i2c_reg_addr  = reg_q;
  assign bus.i2c_value     = val_q;
  assign bus.i2c_is_read   = rd_q;
  assign bus.i2c_enable    = en_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.timeout_seen  = tmo_seen_q;
`else
  assign bus.timeout_seen  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/lock model.
module tb_i2c_bus_arbiter;

  localparam int N   = 3;
  localparam int TMO = 100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32'(TMO))) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Requester-side pending requests.
  logic       v  [N];
  logic       lk [N];
  logic       rd [N];
  logic [6:0] ca [N];
  logic [7:0] ra [N];
  logic [7:0] va [N];

  // Reference model: last released grantee and current lock owner (-1 = none).
  int last_g;
  int lock_own;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = v[i];
      bus.req_lock[i]            = lk[i];
      bus.req_is_read[i]         = rd[i];
      bus.req_chip_addr[7*i +: 7] = ca[i];
      bus.req_reg_addr[8*i +: 8]  = ra[i];
      bus.req_value[8*i +: 8]     = va[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] c, input logic [7:0] r,
                         input logic [7:0] val, input logic isrd, input logic lock);
    v[i] = 1'b1; ca[i] = c; ra[i] = r; va[i] = val; rd[i] = isrd; lk[i] = lock;
    drive();
  endtask

  function automatic int exp_winner();
    if (lock_own >= 0) return v[lock_own] ? lock_own : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(last_g + k) % N]) return (last_g + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_g   = N - 1;
    lock_own = -1;
  endtask

  // Waits (bounded) for the enable strobe; cycles counted from the call.
  task automatic wait_enable(output logic ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60 && !ok; c++) begin
      step();
      if (bus.i2c_enable) begin ok = 1'b1; lat = c; end
    end
    if (!ok) check("enable_wait_expired", 32'd0, 32'd1);
  endtask

  // One full transaction as seen by the master model and the requesters.
  task automatic run_one(input int dly, input logic nack, input logic [7:0] rdata,
                         output int w_out, output int lat);
    int         w;
    logic       ok;
    int         extra;
    logic [7:0] exp_data;
    w     = exp_winner();
    w_out = w;
    if (w < 0) begin check("no_winner_predicted", 32'd0, 32'd1); lat = 0; return; end
    wait_enable(ok, lat);
    if (!ok) return;
    check("grant_id", 32'(bus.grant_id), 32'(w));
    check("chip_addr", 32'(bus.i2c_chip_addr), 32'(ca[w]));
    check("reg_addr", 32'(bus.i2c_reg_addr), 32'(ra[w]));
    check("value", 32'(bus.i2c_value), 32'(va[w]));
    check("is_read", 32'(bus.i2c_is_read), 32'(rd[w]));
    check("busy_issue", 32'(bus.busy), 32'd1);
    bus.i2c_done = 1'b0;
    extra = 0;
    for (int k = 0; k <= dly; k++) begin
      step();
      if (bus.i2c_enable || (|bus.req_ack) || !bus.busy) extra++;
    end
    check("no_extra_strobe", 32'(extra), 32'd0);
    bus.i2c_done      = 1'b1;
    bus.i2c_data      = rdata;
    bus.i2c_ack_error = nack;
    ok = 1'b0;
    for (int c = 1; c <= 4 && !ok; c++) begin
      step();
      if (|bus.req_ack) ok = 1'b1;
    end
    if (!ok) begin check("ack_wait_expired", 32'd0, 32'd1); return; end
    exp_data = rd[w] ? rdata : 8'h00;
    check("req_ack", 32'(bus.req_ack), 32'd1 << w);
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check("rsp_err", 32'(bus.rsp_err), 32'(nack));
    if (lk[w]) lock_own = w;
    else begin lock_own = -1; last_g = w; end
    v[w] = 1'b0;
    drive();
    step();
    check("ack_one_cycle", 32'(bus.req_ack), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("rsp_data_held", 32'(bus.rsp_data), 32'(exp_data));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int   w, lat, prev, cnt;
    logic ok;
    int   got [N];

    for (int i = 0; i < N; i++) begin
      v[i] = 0; lk[i] = 0; rd[i] = 0; ca[i] = '0; ra[i] = '0; va[i] = '0;
    end
    drive();
    bus.i2c_done      = 1'b1;
    bus.i2c_data      = 8'h00;
    bus.i2c_ack_error = 1'b0;
    model_reset();

    // Reset values.
    step(); step();
    check("rst_ack", 32'(bus.req_ack), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_enable", 32'(bus.i2c_enable), 32'd0);
    check("rst_chip", 32'(bus.i2c_chip_addr), 32'd0);
    check("rst_tmo", 32'(bus.timeout_seen), 32'd0);
    reset = 1'b1;
    step();

    // Single write from requester 0: first grant one cycle after the request.
    set_req(0, 7'h38, 8'h08, 8'hBF, 1'b0, 1'b0);
    run_one(20, 1'b0, 8'hEE, w, lat);
    check("first_winner", 32'(w), 32'd0);
    check("first_latency", 32'(lat), 32'd1);

    // Both requesters contend; three transactions each, grants alternate.
    for (int i = 0; i < N; i++) got[i] = 0;
    set_req(0, 7'h38, 8'h10, 8'h11, 1'b0, 1'b0);
    set_req(1, 7'h50, 8'h20, 8'h22, 1'b1, 1'b0);
    prev = -1;
    for (int t = 0; t < 6; t++) begin
      run_one(t % 3, 1'b0, 8'(8'h40 + t), w, lat);
      if (t > 0) begin
        check("alternate", 32'(w != prev), 32'd1);
        check("back_to_back_latency", 32'(lat), 32'd1);
      end
      prev = w;
      if (w >= 0) got[w]++;
      if (w >= 0 && got[w] < 3) set_req(w, ca[w], 8'(ra[w] + 1), 8'(va[w] + 1), rd[w], 1'b0);
    end
    check("three_each_0", 32'(got[0]), 32'd3);
    check("three_each_1", 32'(got[1]), 32'd3);

    // Locked requester 1: write then read run back-to-back ahead of requester 0.
    set_req(1, 7'h38, 8'h09, 8'h01, 1'b0, 1'b1);
    run_one(2, 1'b0, 8'h77, w, lat);
    check("lock_first", 32'(w), 32'd1);
    set_req(0, 7'h50, 8'h30, 8'h33, 1'b0, 1'b0);
    set_req(1, 7'h38, 8'h09, 8'h00, 1'b1, 1'b0);
    run_one(3, 1'b0, 8'h06, w, lat);
    check("lock_second", 32'(w), 32'd1);
    check("lock_read_data", 32'(bus.rsp_data), 32'h06);
    run_one(1, 1'b0, 8'h00, w, lat);
    check("after_lock", 32'(w), 32'd0);

    // NACK on a read, then a normal write.
    set_req(2, 7'h21, 8'h44, 8'h00, 1'b1, 1'b0);
    run_one(2, 1'b1, 8'h5A, w, lat);
    check("nack_winner", 32'(w), 32'd2);
    set_req(0, 7'h38, 8'h45, 8'h12, 1'b0, 1'b0);
    run_one(2, 1'b0, 8'h00, w, lat);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: master never completes; lock must be released.
    set_req(1, 7'h38, 8'h0A, 8'h00, 1'b1, 1'b1);
    wait_enable(ok, lat);
    check("tmo_grant", 32'(bus.grant_id), 32'd1);
    bus.i2c_done = 1'b0;
    cnt = 0;
    for (int s = 1; s <= 300 && cnt == 0; s++) begin
      step();
      if (|bus.req_ack) cnt = s;
    end
    check("tmo_ack_cycle", 32'(cnt), 32'(TMO));
    check("tmo_ack", 32'(bus.req_ack), 32'd2);
    check("tmo_err", 32'(bus.rsp_err), 32'd1);
    check("tmo_data", 32'(bus.rsp_data), 32'd0);
    check("tmo_seen", 32'(bus.timeout_seen), 32'd1);
    lock_own = -1; last_g = 1;
    v[1] = 1'b0; drive();
    step();
    bus.i2c_done = 1'b1;
    set_req(1, 7'h38, 8'h0B, 8'h00, 1'b0, 1'b0);
    set_req(2, 7'h21, 8'h0C, 8'h01, 1'b0, 1'b0);
    run_one(1, 1'b0, 8'h00, w, lat);
    check("tmo_lock_released", 32'(w), 32'd2);
    run_one(1, 1'b0, 8'h00, w, lat);
    check("tmo_sticky", 32'(bus.timeout_seen), 32'd1);
`else
    // Without the watchdog a stuck master simply stalls the arbiter.
    set_req(1, 7'h38, 8'h0A, 8'h00, 1'b1, 1'b0);
    w = exp_winner();
    wait_enable(ok, lat);
    bus.i2c_done = 1'b0;
    cnt = 0;
    for (int s = 1; s <= 150; s++) begin
      step();
      if (|bus.req_ack) cnt++;
    end
    check("stall_no_ack", 32'(cnt), 32'd0);
    check("stall_busy", 32'(bus.busy), 32'd1);
    check("stall_tmo_flag", 32'(bus.timeout_seen), 32'd0);
    bus.i2c_done = 1'b1;
    bus.i2c_data = 8'h3C;
    ok = 1'b0;
    for (int c = 1; c <= 4 && !ok; c++) begin
      step();
      if (|bus.req_ack) ok = 1'b1;
    end
    check("stall_ack", 32'(bus.req_ack), 32'd1 << w);
    check("stall_data", 32'(bus.rsp_data), 32'h3C);
    last_g = w;
    v[1] = 1'b0; drive();
    step();
`endif

    // Reset in WAIT_DONE aborts; re-issue only once done returns.
    set_req(0, 7'h38, 8'h55, 8'hA5, 1'b0, 1'b0);
    wait_enable(ok, lat);
    bus.i2c_done = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("abort_ack", 32'(bus.req_ack), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_enable", 32'(bus.i2c_enable), 32'd0);
    check("abort_grant", 32'(bus.grant_id), 32'd0);
    check("abort_fields", {bus.i2c_chip_addr, bus.i2c_reg_addr, bus.i2c_value, bus.i2c_is_read}, 32'd0);
    check("abort_rsp", {23'd0, bus.rsp_err, bus.rsp_data}, 32'd0);
    step(); step();
    reset = 1'b1;
    model_reset();
    cnt = 0;
    for (int s = 0; s < 5; s++) begin
      step();
      if (bus.i2c_enable || bus.busy || (|bus.req_ack)) cnt++;
    end
    check("wait_for_done", 32'(cnt), 32'd0);
    bus.i2c_done = 1'b1;
    run_one(2, 1'b0, 8'h00, w, lat);
    check("post_reset_winner", 32'(w), 32'd0);
    check("post_reset_latency", 32'(lat), 32'd1);

    // Randomized traffic against the model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1)
          set_req(i, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
      end
      if (lock_own >= 0 && !v[lock_own])
        set_req(lock_own, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      if (!(v[0] || v[1] || v[2]))
        set_req(int'($urandom_range(0, N - 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom), 1'b0);
      run_one(int'($urandom_range(0, 6)), 1'($urandom), 8'($urandom), w, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
